// File: rtl/psum_accumulator.sv
// Per-lane partial-sum accumulator for a systolic array: sums cfg_tiles beats per job,
// optionally saturating, then holds the result until the output handshake.
module psum_accumulator #(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 21,
    parameter int COLS      = 16,
    parameter int BLKS      = 16,
    parameter int TILE_W    = 6,
    parameter int SAT_EN    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [TILE_W-1:0]              cfg_tiles,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BLKS*COLS*IN_WIDTH-1:0]  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BLKS*COLS*OUT_WIDTH-1:0] out_data,
    output logic                           busy,
    output logic                           ovf,
    output logic [1:0]                     dbg_state
);

    localparam int LANES = BLKS * COLS;
    localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in ACCUM; out_valid is high only in DRAIN, and out_data is
    // held stable from DRAIN entry until that transfer.
    state_t              state_q;
    state_t              state_d;
    logic [TILE_W-1:0]   tiles_q;
    logic [TILE_W-1:0]   cnt_q;
    logic [TILE_W-1:0]   tiles_eff;
    logic                ovf_q;
    logic                beat;
    logic                first_beat;
    logic                last_beat;
    logic                drain_hs;
    logic                take_start;
    logic [LANES-1:0]    lane_ovf;

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == DRAIN);
    assign busy       = (state_q != IDLE);
    assign ovf        = ovf_q;
    assign dbg_state  = state_q;

    assign beat       = in_valid && in_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = beat && (cnt_q == tiles_q - TILE_W'(1));
    assign drain_hs   = out_valid && out_ready;
    // A start is honoured from IDLE, or in the DRAIN cycle that completes its handshake.
    assign take_start = start && ((state_q == IDLE) || drain_hs);
    assign tiles_eff  = (cfg_tiles == '0) ? TILE_W'(1) : cfg_tiles;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (last_beat) state_d = DRAIN;
            DRAIN:   if (drain_hs) state_d = start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tiles_q <= TILE_W'(1);
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_start) begin
                tiles_q <= tiles_eff;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else if (beat) begin
                cnt_q <= cnt_q + TILE_W'(1);
                // The first beat overwrites stale content, so its sum is meaningless.
                if (!first_beat && (|lane_ovf)) ovf_q <= 1'b1;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IN_WIDTH-1:0]  lane_in;
        logic [OUT_WIDTH:0]   in_ext;
        logic [OUT_WIDTH:0]   acc_ext;
        logic [OUT_WIDTH:0]   sum;
        logic [OUT_WIDTH-1:0] acc_q;
        logic [OUT_WIDTH-1:0] acc_d;

        assign lane_in     = in_data[IN_WIDTH*l +: IN_WIDTH];
        assign in_ext      = {{(OUT_WIDTH+1-IN_WIDTH){lane_in[IN_WIDTH-1]}}, lane_in};
        assign acc_ext     = {acc_q[OUT_WIDTH-1], acc_q};
        assign sum         = acc_ext + in_ext;
        assign lane_ovf[l] = sum[OUT_WIDTH] ^ sum[OUT_WIDTH-1];

        always_comb begin
            acc_d = acc_q;
            if (beat) begin
                if (first_beat) begin
                    acc_d = in_ext[OUT_WIDTH-1:0];
                end else if (lane_ovf[l] && (SAT_EN != 0)) begin
                    acc_d = sum[OUT_WIDTH] ? MIN_VAL : MAX_VAL;
                end else begin
                    acc_d = sum[OUT_WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) acc_q <= '0;
            else        acc_q <= acc_d;
        end

        assign out_data[OUT_WIDTH*l +: OUT_WIDTH] = acc_q;
    end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 18, meaning the signed width of each incoming partial-sum lane.
REQ-002 SHALL have parameter OUT_WIDTH, default 21, meaning the signed width of each accumulator lane, with OUT_WIDTH >= IN_WIDTH.
REQ-003 SHALL have parameter COLS, default 16, meaning the systolic columns per PE block.
REQ-004 SHALL have parameter BLKS, default 16, meaning the PE block count; lanes = BLKS*COLS.
REQ-005 SHALL have parameter TILE_W, default 6, meaning the width of the tile-count configuration.
REQ-006 SHALL have parameter SAT_EN, default 1, meaning 1 selects saturating addition and 0 selects two's-complement wrap.
REQ-007 SHALL have port clk, input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-008 SHALL have port rst_n, input, width 1, an asynchronous active-low reset.
REQ-009 SHALL have port start, input, width 1, which begins a job.
REQ-010 SHALL have port cfg_tiles, input, width TILE_W, giving the number of partial-sum beats per job and sampled on start.
REQ-011 SHALL have port in_valid, input, width 1, and port in_ready, output, width 1, forming the input handshake.
REQ-012 SHALL have port in_data, input, width BLKS*COLS*IN_WIDTH; lane L occupies bits [IN_WIDTH*(L+1)-1 : IN_WIDTH*L], with L = blk*COLS+col.
REQ-013 SHALL have port out_valid, output, width 1, and port out_ready, input, width 1, forming the output handshake.
REQ-014 SHALL have port out_data, output, width BLKS*COLS*OUT_WIDTH, using the same lane packing as in_data at OUT_WIDTH.
REQ-015 SHALL have port busy, output, width 1, which is high whenever the state is not IDLE.
REQ-016 SHALL have port ovf, output, width 1, a sticky per-job flag set if any lane saturated (SAT_EN=1) or wrapped (SAT_EN=0).

Function
REQ-017 SHALL implement the states IDLE, ACCUM and DRAIN.
REQ-018 In IDLE, start=1 SHALL latch tiles_q = max(cfg_tiles,1), clear the beat counter and ovf, and move to ACCUM on the next edge.
REQ-019 In ACCUM, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-020 A beat SHALL be accepted when in_valid && in_ready; no state or accumulator change SHALL occur on cycles without acceptance.
REQ-021 On the first accepted beat of a job, every lane SHALL load the sign-extended in_data lane, discarding any prior content; no separate clear cycle SHALL be required.
REQ-022 On each later beat, every lane SHALL compute acc + sext(in) at OUT_WIDTH+1 bits; with SAT_EN=1 the result SHALL clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; with SAT_EN=0 it SHALL truncate to OUT_WIDTH bits.
REQ-023 ovf SHALL be set on the edge of any beat where any lane's OUT_WIDTH+1-bit sum is out of range, and SHALL hold until the next accepted start or reset.
REQ-024 When the beat numbered tiles_q is accepted, the FSM SHALL move to DRAIN, and out_valid SHALL be 1 on the following cycle (latency of 1 cycle from the last accepted beat).
REQ-025 In DRAIN, out_data SHALL equal the accumulator registers, and out_data and out_valid SHALL remain stable until out_valid && out_ready.
REQ-026 On the DRAIN handshake, the FSM SHALL move to IDLE; if start=1 in that same cycle, it SHALL instead latch cfg_tiles and go directly to ACCUM (back-to-back jobs).
REQ-027 start SHALL be ignored in ACCUM, and in DRAIN when no handshake occurs in that cycle.
REQ-028 out_valid SHALL be 0 outside DRAIN; out_data SHALL hold the last accumulator value outside DRAIN.
REQ-029 With cfg_tiles=1, the single accepted beat SHALL go to DRAIN holding sext(in_data).
REQ-030 The beat counter SHALL be TILE_W bits wide and SHALL never wrap within a job.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, with in_ready=0, out_valid=0, busy=0, ovf=0, out_data=0, the counter at 0 and tiles_q at 1.
REQ-032 An assertion of rst_n during ACCUM or DRAIN SHALL abandon the job with no output handshake; after release, the block SHALL wait for a new start.

Verification
REQ-033 The bench SHALL cover: IN=18, OUT=21, cfg_tiles=3, lane 0 beats 5, -2, 7 -> one cycle after the third beat out_valid=1 and lane 0 = 10, ovf=0.
REQ-034 The bench SHALL cover: SAT_EN=1, lane 5 with 16 beats of +131071 and tiles=16 -> lane 5 = 1048575 (clamped), ovf=1; with SAT_EN=0 -> lane 5 = the truncated value 2097136 read as signed (-16), ovf=1.
REQ-035 The bench SHALL cover: in_valid toggled 1,0,0,1,1 with tiles=3 -> accumulate only on the 3 valid cycles; out_valid rises after the 5th cycle.
REQ-036 The bench SHALL cover: out_ready held 0 for 4 cycles in DRAIN -> out_data stable and in_ready=0; start pulsed during the stall is ignored.
REQ-037 The bench SHALL cover: start asserted in the same cycle as the DRAIN handshake, cfg_tiles=0 -> next state ACCUM with tiles=1, and the new result equals sext of the single beat.
REQ-038 The bench SHALL cover: rst_n pulsed low after beat 2 of 4 -> all outputs at reset values; a subsequent job with tiles=2 produces no residue from the aborted job.
